// File: rtl/vertex_write_buffer_if.sv
// Upstream write port and downstream memory write port of the vertex write buffer.
interface vertex_write_buffer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             wrEn;
    logic [WIDTH-1:0] wrAddr;
    logic [WIDTH-1:0] wrData;
    logic             stall;
    logic [WIDTH-1:0] memAddr;
    logic [WIDTH-1:0] memData;
    logic             memValid;
    logic             memReady;
    logic             idle;
    logic             overflow;
    logic             clearError;

    modport master (
        output wrEn, wrAddr, wrData, memReady, clearError,
        input  stall, memAddr, memData, memValid, idle, overflow
    );

    modport slave (
        input  wrEn, wrAddr, wrData, memReady, clearError,
        output stall, memAddr, memData, memValid, idle, overflow
    );
endinterface

// File: rtl/vertex_write_buffer.sv
// FIFO of {address, data} writes between the matrix processor datapath and memory,
// with early backpressure and a sticky overflow flag for dropped writes.
module vertex_write_buffer #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned STALL_SLACK = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    vertex_write_buffer_if.slave bus
);
    localparam int unsigned AW         = $clog2(DEPTH);
    localparam logic [AW:0] Full       = (AW + 1)'(DEPTH);
    localparam logic [AW:0] StallLevel = (AW + 1)'(DEPTH - STALL_SLACK);

    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] addr_q [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];
    logic             full, pop, push, drop;

    always_comb begin
        full = (count_q == Full);
        pop  = (count_q != '0) && bus.memReady;
        // A full buffer still takes a write when the head leaves in the same cycle.
        push = bus.wrEn && (!full || pop);
        drop = bus.wrEn && full && !pop;

        rd_ptr_d = rd_ptr_q + AW'(pop);
        wr_ptr_d = wr_ptr_q + AW'(push);

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A drop wins over a same-cycle clear so no lost write goes unreported.
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (bus.clearError) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage is not reset; memValid only exposes slots that were written.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= bus.wrAddr;
            data_q[wr_ptr_q] <= bus.wrData;
        end
    end

    assign bus.memValid = (count_q != '0);
    assign bus.memAddr  = addr_q[rd_ptr_q];
    assign bus.memData  = data_q[rd_ptr_q];
    assign bus.stall    = (count_q >= StallLevel);
    assign bus.idle     = (count_q == '0);
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_vertex_write_buffer.sv
// Scoreboard bench: stimulus queues expected memory writes, a negedge monitor checks deliveries.
module tb_vertex_write_buffer;
    localparam int unsigned WIDTH = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [2*WIDTH-1:0] exp_q [$];

    vertex_write_buffer_if #(.WIDTH(WIDTH)) bus ();

    vertex_write_buffer #(
        .WIDTH       (WIDTH),
        .DEPTH       (8),
        .STALL_SLACK (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One write strobe; the expected delivery is queued only when acceptance is expected.
    task automatic do_write(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d,
                            input bit expect_accept);
        bus.wrEn   = 1'b1;
        bus.wrAddr = a;
        bus.wrData = d;
        if (expect_accept) exp_q.push_back({a, d});
        tick();
        bus.wrEn   = 1'b0;
        bus.wrAddr = 'x;
        bus.wrData = 'x;
    endtask

    task automatic drain(input int budget);
        bus.memReady = 1'b1;
        for (int k = 0; k < budget; k++) begin
            if (bus.idle && exp_q.size() == 0) break;
            tick();
        end
        chk("drain idle", 64'(bus.idle), 64'd1);
        chk("drain queue empty", 64'(exp_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.memValid && bus.memReady) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL delivery: unexpected %0h/%0h with nothing outstanding",
                         bus.memAddr, bus.memData);
            end else begin
                logic [2*WIDTH-1:0] e;
                e = exp_q.pop_front();
                if ({bus.memAddr, bus.memData} !== e) begin
                    errors++;
                    $display("FAIL delivery: got %0h/%0h expected %0h/%0h",
                             bus.memAddr, bus.memData, e[2*WIDTH-1:WIDTH], e[WIDTH-1:0]);
                end
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] a_tab [3];
        logic [WIDTH-1:0] d_tab [3];
        int sent;
        checks = 0;
        errors = 0;
        a_tab = '{32'h100, 32'h104, 32'h108};
        d_tab = '{32'h11, 32'h22, 32'h33};
        bus.wrEn = 1'b0;
        bus.wrAddr = '0;
        bus.wrData = '0;
        bus.memReady = 1'b0;
        bus.clearError = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        chk("reset memValid", 64'(bus.memValid), 64'd0);
        chk("reset idle", 64'(bus.idle), 64'd1);
        chk("reset stall", 64'(bus.stall), 64'd0);
        chk("reset overflow", 64'(bus.overflow), 64'd0);
        rst_n = 1'b1;

        // Streaming writes, each visible one cycle after its strobe
        bus.memReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_write(a_tab[i], d_tab[i], 1'b1);
            chk("latency memValid", 64'(bus.memValid), 64'd1);
            chk("latency memAddr", 64'(bus.memAddr), 64'(a_tab[i]));
        end
        tick();
        chk("stream idle", 64'(bus.idle), 64'd1);

        // Blocked memory: stall threshold, head hold, overflow on the 9th write
        bus.memReady = 1'b0;
        for (int i = 0; i < 9; i++) begin
            do_write(32'h100 + 32'(4 * i), 32'(32'h11 * (i + 1)), i < 8);
            chk("hold memAddr", 64'(bus.memAddr), 64'h100);
            chk("hold memData", 64'(bus.memData), 64'h11);
            chk("stall level", 64'(bus.stall), (i >= 5) ? 64'd1 : 64'd0);
            chk("overflow on drop", 64'(bus.overflow), (i == 8) ? 64'd1 : 64'd0);
        end
        tick();
        chk("overflow sticky", 64'(bus.overflow), 64'd1);
        bus.clearError = 1'b1;
        tick();
        bus.clearError = 1'b0;
        chk("overflow cleared", 64'(bus.overflow), 64'd0);

        // Full buffer with same-cycle push and pop keeps count at DEPTH
        bus.memReady = 1'b1;
        do_write(32'h200, 32'hAA, 1'b1);
        bus.memReady = 1'b0;
        chk("full push+pop overflow", 64'(bus.overflow), 64'd0);
        chk("full push+pop stall", 64'(bus.stall), 64'd1);
        chk("full push+pop head", 64'(bus.memAddr), 64'h104);
        do_write(32'h204, 32'hBB, 1'b0);
        chk("still full after push+pop", 64'(bus.overflow), 64'd1);
        bus.clearError = 1'b1;
        do_write(32'h208, 32'hCC, 1'b0);
        chk("drop beats clear", 64'(bus.overflow), 64'd1);
        tick();
        bus.clearError = 1'b0;
        chk("clear after drop", 64'(bus.overflow), 64'd0);
        drain(40);

        // Random memReady across pointer wrap; upstream honours stall
        sent = 0;
        for (int cyc = 0; cyc < 400 && sent < 20; cyc++) begin
            bus.memReady = 1'($urandom_range(0, 1));
            if (!bus.stall) begin
                bus.wrEn   = 1'b1;
                bus.wrAddr = 32'h1000 + 32'(4 * sent);
                bus.wrData = 32'hC0DE0000 + 32'(sent);
                exp_q.push_back({bus.wrAddr, bus.wrData});
                sent++;
            end else begin
                bus.wrEn = 1'b0;
            end
            tick();
        end
        bus.wrEn = 1'b0;
        chk("random all issued", 64'(sent), 64'd20);
        drain(60);

        // Reset with five entries buffered and overflow set
        bus.memReady = 1'b0;
        for (int i = 0; i < 9; i++) begin
            do_write(32'h400 + 32'(4 * i), 32'h70 + 32'(i), i < 8);
        end
        bus.memReady = 1'b1;
        repeat (3) tick();
        bus.memReady = 1'b0;
        chk("pre-reset overflow", 64'(bus.overflow), 64'd1);
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        chk("mid reset memValid", 64'(bus.memValid), 64'd0);
        chk("mid reset idle", 64'(bus.idle), 64'd1);
        chk("mid reset stall", 64'(bus.stall), 64'd0);
        chk("mid reset overflow", 64'(bus.overflow), 64'd0);
        bus.memReady = 1'b1;
        do_write(32'h300, 32'h55, 1'b1);
        chk("post reset memAddr", 64'(bus.memAddr), 64'h300);
        chk("post reset memData", 64'(bus.memData), 64'h55);
        tick();
        chk("post reset idle", 64'(bus.idle), 64'd1);
        chk("final queue empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
